aes_rkey_seq: RTL and testbench
===============================

# aes_rkey_seq

Round-key sequencer between `aes_kexp` and the iterative cipher/decipher datapath. It snapshots the expanded key schedule on a start request. It then issues one 128-bit round key per accepted handshake, in ascending order for encryption and descending order for decryption. Optionally it applies InvMixColumns for the equivalent inverse cipher.

## Interface
Parameters: none at module level; taken from `aes_const`:
- `Nb`, 4: words per state/round key
- `Nk`, 4/6/8: key words
- `Nr`, 10/12/14: rounds; the schedule holds `Nb*(Nr+1)` words

Ports:
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `KExp`  in  32 x `Nb*(Nr+1)`  expanded key words from `aes_kexp`; word 0 = first key word, byte 0 in bits 31:24
- `kexp_valid`  in  1  `KExp` is stable and consistent
- `start`  in  1  request a round-key sequence
- `dec`  in  1  direction, sampled with `start`: 0 = encrypt order, 1 = decrypt order
- `busy`  out  1  sequence in progress
- `rk_valid`  out  1  `rk_data` holds a valid round key
- `rk_ready`  in  1  consumer accepts `rk_data`
- `rk_data`  out  128  round key `{W[4r],W[4r+1],W[4r+2],W[4r+3]}`, `W[4r]` in bits 127:96
- `rk_round`  out  4  round index r of `rk_data`
- `rk_last`  out  1  `rk_data` is the final key of the sequence
- `done`  out  1  one-cycle pulse after the final transfer

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: `start && kexp_valid` causes the following on the same edge:
  - copy all `KExp` words into the internal snapshot
  - latch `dec`
  - load the first key into `rk_data` directly from `KExp`: round 0 for encrypt, round Nr for decrypt
  - set `rk_valid`; go to ISSUE
- `start` is ignored when `kexp_valid` = 0.
- `start` is ignored in ISSUE and DONE.
- ISSUE: a transfer occurs when `rk_valid && rk_ready`.
  - On a non-last transfer, load the next round from the snapshot: r+1 for encrypt, r-1 for decrypt.
  - On the last transfer (r = Nr for encrypt, r = 0 for decrypt), clear `rk_valid` and go to DONE.
- Without a transfer, `rk_data`, `rk_round` and `rk_last` hold unchanged.
- `rk_last` = 1 exactly when `rk_round` equals the terminal round for the latched direction.
- DONE: `done` = 1 for one cycle, then IDLE.
- `busy` = 1 in ISSUE and DONE.
- Changes to `KExp` after acceptance do not affect the sequence in progress.
- Reset values: `busy`, `rk_valid`, `rk_last`, `done` = 0; `rk_data` = 0; `rk_round` = 0; snapshot cleared; state IDLE.
- Reset mid-sequence aborts immediately. No `done` pulse is produced.

## Timing
- Accepting `start` at edge T gives `rk_valid` = 1 from T+1 with the first key.
- With `rk_ready` held high: one key per cycle, Nr+1 consecutive transfers, no bubbles.
- `done` is high in the cycle after the last transfer. The next `start` is accepted at the edge ending the DONE cycle +1 (first IDLE cycle).
- All outputs are registered. No combinational path from `rk_ready` or `start` to any output.
- `rk_round` is a 4-bit unsigned counter and never wraps: range is 0..Nr.

## Configuration
- `AES_EQINV_EN` defined:
  - With `dec` = 1, rounds 1..Nr-1 are loaded as InvMixColumns(key), per column in GF(2^8) with polynomial 0x11B and coefficients {0e,0b,0d,09}.
  - Rounds 0 and Nr are never transformed. Encryption is unaffected.
  - The transform sits in the next-key load path, so throughput is unchanged.
- `AES_EQINV_EN` undefined: keys are always raw schedule words and no InvMixColumns logic is present.

## Test plan
- Encrypt order, AES-128 key 000102…0f, `rk_ready` = 1:
  - transfers r = 0..10
  - r0 = 000102030405060708090a0b0c0d0e0f
  - r1 = d6aa74fdd2af72fadaa678f1d6ab76fe
  - r10 = 13111d7fe3944a17f307a78b4d2b30c5, with `rk_last` = 1
  - `done` pulses one cycle later
- Decrypt order, same key, macro undefined:
  - first = 13111d7f… (`rk_round` 10)
  - second = 549932d1f08557681093ed9cbe2c974e
  - last = 000102…0f (`rk_round` 0)
- Decrypt with `AES_EQINV_EN`:
  - second key (`rk_round` 9) = 13aa29be9c8faff6f770f58000f7bf03
  - first and last keys are identical to the raw schedule
- Backpressure: drop `rk_ready` for 3 cycles at r = 4 → `rk_data` and `rk_round` hold; the sequence resumes at r = 5 with no key skipped or duplicated.
- Ignored starts:
  - `start` while `busy` → no effect on order or count
  - `start` with `kexp_valid` = 0 → stays IDLE, `rk_valid` = 0
- Reset at r = 6 → next cycle all outputs 0 and no `done` pulse; a fresh `start` restarts at r = 0.

Source files
------------

// File: rtl/aes_rkey_seq.sv
// Round-key sequencer: snapshots the expanded AES key schedule and issues round keys in
// encrypt or decrypt order. Optional macro AES_EQINV_EN applies InvMixColumns to decrypt rounds 1..Nr-1.

package aes_const;
    localparam int Nb = 4;
    localparam int Nk = 4;
    localparam int Nr = Nk + 6;
endpackage

module aes_rkey_seq
    import aes_const::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  KExp [0:Nb*(Nr+1)-1],
    input  logic         kexp_valid,
    input  logic         start,
    input  logic         dec,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         done
);

    localparam int         NW     = Nb * (Nr + 1);
    localparam logic [3:0] LAST_R = 4'(Nr);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t       state;
    logic [31:0]  snap [0:NW-1];
    logic         dec_q;
    logic         xfer;
    logic [3:0]   next_r;
    logic [5:0]   base;
    logic         next_last;
    logic [127:0] first_key;
    logic [127:0] next_raw;
    logic [127:0] next_key;

`ifdef AES_EQINV_EN
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of InvMixColumns; byte 0 of the column sits in bits 31:24.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int j = 0; j < 4; j++) begin
            a[j]  = w[31-8*j -: 8];
            x2    = xt(a[j]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[j] = x8 ^ a[j];
            mb[j] = x8 ^ x2 ^ a[j];
            md[j] = x8 ^ x4 ^ a[j];
            me[j] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] k);
        return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
                inv_mix_col(k[63:32]), inv_mix_col(k[31:0])};
    endfunction
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        xfer   = rk_valid && rk_ready;
        next_r = rk_round;
        // Saturate at the terminal round so the snapshot index never leaves the schedule.
        if (dec_q) begin
            if (rk_round != 4'd0) next_r = rk_round - 4'd1;
        end else begin
            if (rk_round != LAST_R) next_r = rk_round + 4'd1;
        end
        next_last = dec_q ? (next_r == 4'd0) : (next_r == LAST_R);
        base      = {next_r, 2'b00};
        next_raw  = {snap[base], snap[base + 6'd1], snap[base + 6'd2], snap[base + 6'd3]};
        first_key = dec ? {KExp[4*Nr], KExp[4*Nr+1], KExp[4*Nr+2], KExp[4*Nr+3]}
                        : {KExp[0], KExp[1], KExp[2], KExp[3]};
`ifdef AES_EQINV_EN
        next_key  = (dec_q && next_r != 4'd0 && next_r != LAST_R) ? inv_mix(next_raw) : next_raw;
`else
        next_key  = next_raw;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            dec_q    <= 1'b0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_round <= '0;
            rk_last  <= 1'b0;
            done     <= 1'b0;
            // NOTE: the snapshot is cleared on reset so no stale key material survives an abort.
            for (int i = 0; i < NW; i++) snap[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && kexp_valid) begin
                        for (int i = 0; i < NW; i++) snap[i] <= KExp[i];
                        dec_q    <= dec;
                        rk_data  <= first_key;
                        rk_round <= dec ? LAST_R : 4'd0;
                        rk_last  <= 1'b0;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        if (rk_last) begin
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            rk_data  <= next_key;
                            rk_round <= next_r;
                            rk_last  <= next_last;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_rkey_seq.sv
// Directed testbench for aes_rkey_seq using the AES-128 schedule of key 000102..0f.
module tb_aes_rkey_seq;
    import aes_const::*;

    localparam int NW = Nb * (Nr + 1);

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  kexp [0:NW-1];
    logic         kexp_valid = 1'b0;
    logic         start = 1'b0;
    logic         dec = 1'b0;
    logic         rk_ready = 1'b0;
    logic         busy, rk_valid, rk_last, done;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] rk_tab [0:10];

    aes_rkey_seq dut (
        .clock(clock), .reset(reset), .KExp(kexp), .kexp_valid(kexp_valid),
        .start(start), .dec(dec), .busy(busy), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .rk_data(rk_data), .rk_round(rk_round),
        .rk_last(rk_last), .done(done)
    );

    always #5 clock = ~clock;

`ifdef AES_EQINV_EN
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] k);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = k[127-32*c-8*j -: 8];
            for (int j = 0; j < 4; j++)
                o[127-32*c-8*j -: 8] = gmul(a[j], 8'h0e) ^ gmul(a[(j+1)%4], 8'h0b)
                                     ^ gmul(a[(j+2)%4], 8'h0d) ^ gmul(a[(j+3)%4], 8'h09);
        end
        return o;
    endfunction
`endif

    function automatic logic [127:0] exp_key(input int r, input logic d);
        logic [127:0] k = rk_tab[r];
`ifdef AES_EQINV_EN
        if (d && r > 0 && r < Nr) k = inv_mix(k);
`endif
        return k;
    endfunction

    task automatic load_kexp(input logic corrupt);
        for (int r = 0; r <= Nr; r++)
            for (int i = 0; i < 4; i++)
                kexp[4*r+i] = corrupt ? ~rk_tab[r][127-32*i -: 32] : rk_tab[r][127-32*i -: 32];
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({busy, rk_valid, rk_last, done, rk_round, rk_data} !== '0) begin
            n_errors++;
            $display("FAIL reset_state got busy=%b valid=%b last=%b done=%b round=%0d data=%h, need all zero",
                     busy, rk_valid, rk_last, done, rk_round, rk_data);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({busy, rk_valid, done} !== 3'b000) begin
            n_errors++;
            $display("FAIL idle_after_reset got busy=%b valid=%b done=%b, need 000", busy, rk_valid, done);
        end
    endtask

    task automatic test_encrypt;
        start = 1'b1; dec = 1'b0; rk_ready = 1'b1; kexp_valid = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int r = 0; r <= Nr; r++) begin
            n_checks++;
            if ({rk_valid, rk_round, rk_last, done, busy} !== {1'b1, 4'(r), r == Nr, 1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL enc_ctrl r=%0d got valid=%b round=%0d last=%b done=%b busy=%b",
                         r, rk_valid, rk_round, rk_last, done, busy);
            end
            n_checks++;
            if (rk_data !== exp_key(r, 1'b0)) begin
                n_errors++;
                $display("FAIL enc_key r=%0d got %h need %h", r, rk_data, exp_key(r, 1'b0));
            end
            if (r == 1) begin
                n_checks++;
                if (rk_data !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin
                    n_errors++;
                    $display("FAIL enc_r1_literal got %h need d6aa74fdd2af72fadaa678f1d6ab76fe", rk_data);
                end
            end
            @(negedge clock);
        end
        n_checks++;
        if ({done, rk_valid, busy} !== 3'b101) begin
            n_errors++;
            $display("FAIL enc_done got done=%b valid=%b busy=%b, need 1 0 1", done, rk_valid, busy);
        end
        start = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({done, rk_valid, busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL enc_done_pulse got done=%b valid=%b busy=%b, need 000", done, rk_valid, busy);
        end
    endtask

    task automatic test_back_to_back;
        // start has been high since the DONE cycle; it is taken in the first IDLE cycle.
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if ({rk_valid, rk_round, rk_data} !== {1'b1, 4'd0, rk_tab[0]}) begin
            n_errors++;
            $display("FAIL b2b_first got valid=%b round=%0d data=%h", rk_valid, rk_round, rk_data);
        end
        for (int r = 0; r <= Nr; r++) begin
            n_checks++;
            if (rk_round !== 4'(r)) begin
                n_errors++;
                $display("FAIL b2b_round got %0d need %0d", rk_round, r);
            end
            @(negedge clock);
        end
        @(negedge clock);
    endtask

    task automatic test_decrypt;
        start = 1'b1; dec = 1'b1; rk_ready = 1'b1;
        @(negedge clock);
        start = 1'b0; dec = 1'b0;
        for (int r = Nr; r >= 0; r--) begin
            n_checks++;
            if ({rk_valid, rk_round, rk_last} !== {1'b1, 4'(r), r == 0}) begin
                n_errors++;
                $display("FAIL dec_ctrl r=%0d got valid=%b round=%0d last=%b", r, rk_valid, rk_round, rk_last);
            end
            n_checks++;
            if (rk_data !== exp_key(r, 1'b1)) begin
                n_errors++;
                $display("FAIL dec_key r=%0d got %h need %h", r, rk_data, exp_key(r, 1'b1));
            end
            if (r == Nr - 1) begin
                n_checks++;
`ifdef AES_EQINV_EN
                if (rk_data !== 128'h13aa29be9c8faff6f770f58000f7bf03) begin
                    n_errors++;
                    $display("FAIL dec_second got %h need 13aa29be9c8faff6f770f58000f7bf03", rk_data);
                end
`else
                if (rk_data !== 128'h549932d1f08557681093ed9cbe2c974e) begin
                    n_errors++;
                    $display("FAIL dec_second got %h need 549932d1f08557681093ed9cbe2c974e", rk_data);
                end
`endif
            end
            if (r == 0) begin
                n_checks++;
                if (rk_data !== 128'h000102030405060708090a0b0c0d0e0f) begin
                    n_errors++;
                    $display("FAIL dec_last got %h need 000102030405060708090a0b0c0d0e0f", rk_data);
                end
            end
            @(negedge clock);
        end
        n_checks++;
        if ({done, rk_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL dec_done got done=%b valid=%b, need 1 0", done, rk_valid);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_backpressure;
        int er = 0;
        int hold = 0;
        start = 1'b1; dec = 1'b0; rk_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        load_kexp(1'b1);
        for (int cyc = 0; cyc < 20 && er <= Nr; cyc++) begin
            n_checks++;
            if ({rk_valid, rk_round, rk_last, rk_data} !== {1'b1, 4'(er), er == Nr, exp_key(er, 1'b0)}) begin
                n_errors++;
                $display("FAIL bp_key cyc=%0d got valid=%b round=%0d last=%b data=%h need round %0d data %h",
                         cyc, rk_valid, rk_round, rk_last, rk_data, er, exp_key(er, 1'b0));
            end
            start = (er == 2);
            dec   = (er == 2);
            if (er == 4 && hold < 3) begin
                rk_ready = 1'b0;
                hold++;
            end else begin
                rk_ready = 1'b1;
                er++;
            end
            @(negedge clock);
        end
        start = 1'b0; dec = 1'b0; rk_ready = 1'b1;
        load_kexp(1'b0);
        n_checks++;
        if ({done, rk_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL bp_done got done=%b valid=%b, need 1 0", done, rk_valid);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_ignored_start;
        kexp_valid = 1'b0; start = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({rk_valid, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL start_no_kexp got valid=%b busy=%b, need 0 0", rk_valid, busy);
        end
        start = 1'b0; kexp_valid = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        start = 1'b1; dec = 1'b0; rk_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int r = 0; r <= 6; r++) begin
            n_checks++;
            if (rk_round !== 4'(r)) begin
                n_errors++;
                $display("FAIL rst_mid_round got %0d need %0d", rk_round, r);
            end
            if (r == 6) reset = 1'b1;
            @(negedge clock);
        end
        n_checks++;
        if ({busy, rk_valid, rk_last, done, rk_round, rk_data} !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs got busy=%b valid=%b last=%b done=%b round=%0d data=%h, need all zero",
                     busy, rk_valid, rk_last, done, rk_round, rk_data);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({done, rk_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_mid_no_done got done=%b valid=%b, need 0 0", done, rk_valid);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int r = 0; r <= 1; r++) begin
            n_checks++;
            if ({rk_valid, rk_round, rk_data} !== {1'b1, 4'(r), rk_tab[r]}) begin
                n_errors++;
                $display("FAIL rst_restart r=%0d got valid=%b round=%0d data=%h", r, rk_valid, rk_round, rk_data);
            end
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_tab[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_tab[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_tab[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_tab[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_tab[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_tab[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_tab[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_tab[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_tab[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_tab[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        load_kexp(1'b0);

        test_reset();
        test_encrypt();
        test_back_to_back();
        test_decrypt();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
